ram_scan_detector: RTL and testbench
====================================

Name: ram_scan_detector

Overview:
Parametrised successor to the team's single-port RAM. It adds a scan engine that streams one selected bit from a run of consecutive RAM words into a configurable sequence detector. Host reads and writes work as before, with a registered read address. The scan engine reports match pulses, a match count and the address of the last match. The block is the RAM-plus-detector core of the sequence-detector design, with pattern, width and depth all parameters.

Parameters:
RAM_WIDTH, 8, data word width
ADDR_SIZE, 5, address width
RAM_DEPTH, 32, number of words; must equal 2**ADDR_SIZE
BIT_SEL, 3, bit of each word fed to the detector (0..RAM_WIDTH-1)
PAT_LEN, 3, pattern length in bits (1..8)
PATTERN, 3'b001, target sequence; MSB = oldest scanned bit

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en_write  in  1  write strobe; ignored while busy
en_read  in  1  read strobe; ignored while busy
addr  in  ADDR_SIZE  host read/write address
data_in  in  RAM_WIDTH  write data
data_out  out  RAM_WIDTH  mem[rd_addr]
dout  out  1  data_out[BIT_SEL]
start  in  1  scan request, sampled only when idle
scan_base  in  ADDR_SIZE  first scan address, latched on start
scan_len  in  ADDR_SIZE+1  number of words to scan, latched on start
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan end
detect  out  1  one-cycle pulse per match
det_count  out  ADDR_SIZE+1  matches in current/last scan; saturates at all-ones
det_addr  out  ADDR_SIZE  address of the word completing the most recent match

Behaviour:
- Reset (async, rst_n=0):
  - rd_addr=0, busy=0, done=0, detect=0, det_count=0, det_addr=0.
  - Shift register and fill counter are cleared; FSM goes to IDLE.
  - RAM contents are not cleared and are retained across reset.
  - Reset mid-scan aborts the scan immediately; no done pulse is generated.
- Host access (IDLE only), priority en_write > start > en_read:
  - Write: mem[addr]<=data_in at the edge.
  - Read: rd_addr<=addr at the edge; data_out/dout are valid in the following cycle.
  - No strobe asserted: no state change.
- FSM: IDLE -> SCAN -> IDLE.
- Start at edge S (start=1 in IDLE, en_write=0):
  - Latch base and length; effective length is L=min(scan_len, RAM_DEPTH).
  - Clear det_count, shift register and fill counter.
  - If L=0: done<=1 at S, busy stays 0, FSM stays IDLE.
  - Otherwise: busy<=1 and rd_addr<=scan_base at S.
- SCAN, address stepping:
  - At edge S+k, rd_addr<=(scan_base+k) mod RAM_DEPTH, for k=0..L-1.
  - Address wrap from RAM_DEPTH-1 to 0 is natural.
- SCAN, detection:
  - At edge S+k+1, the bit for index k (dout) is shifted into the PAT_LEN-bit register as its LSB, and fill increments, saturating at PAT_LEN.
  - If the new register value equals PATTERN and fill reaches PAT_LEN on this shift, then at the same edge:
    - detect<=1 for one cycle,
    - det_count increments (saturating),
    - det_addr<=address of index k.
  - Overlapping matches are counted.
- End of scan at edge S+L:
  - The last bit is evaluated.
  - busy<=0, done<=1 for one cycle, FSM returns to IDLE.
  - det_count and det_addr hold until the next start or reset.
- Ignored inputs:
  - en_write, en_read and start are ignored while busy.
  - start coinciding with en_write in IDLE is dropped; it is not queued.
- After a scan, rd_addr holds the last scanned address until the next host read.

Test Plan:
1. Reset then read: assert rst_n=0 mid-cycle -> all outputs 0 immediately; write mem[4]=8'hA5, read addr 4 -> data_out=8'hA5 and dout=0 one cycle after en_read.
2. Basic scan: write addresses 0..7 so that bit3 = 0,0,1,0,0,1,1,0; start with base=0, len=8 -> busy high 8 cycles; detect pulses at edges S+3 and S+6; done at S+8; det_count=2; det_addr=5.
3. Wrap-around: write addresses 30,31,0,1 with bit3 = 1,0,0,1 (others 0); base=30, len=4 -> rd_addr sequence 30,31,0,1; one match; det_addr=1; det_count=1.
4. Fill guard and zero length: scan base=0, len=1 with bit3=1 -> no detect (fill<3), det_count=0; then len=0 -> done pulse at the start edge, busy never asserted.
5. Ignored traffic and clamp: during a 32-word scan, assert en_write to addr 2 and start -> mem[2] unchanged, scan not restarted; scan_len=40 -> exactly 32 words scanned, done at S+32.
6. Reset mid-scan: rst_n low at S+3 -> busy, detect and det_count cleared immediately, no done pulse; RAM still reads back the previously written data.

Source files
------------

// File: rtl/ram_scan_detector.sv
// Single-port RAM with a scan engine that streams one bit per word through a sequence detector.
// Host reads/writes are accepted only while idle; a scan walks consecutive addresses with wrap.
module ram_scan_detector #(
  parameter int unsigned RAM_WIDTH = 8,
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned RAM_DEPTH = 32,
  parameter int unsigned BIT_SEL   = 3,
  parameter int unsigned PAT_LEN   = 3,
  parameter logic [PAT_LEN-1:0] PATTERN = 3'b001
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_write_i,
  input  logic                 en_read_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [RAM_WIDTH-1:0] data_in_i,
  output logic [RAM_WIDTH-1:0] data_out_o,
  output logic                 dout_o,
  input  logic                 start_i,
  input  logic [ADDR_SIZE-1:0] scan_base_i,
  input  logic [ADDR_SIZE:0]   scan_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 detect_o,
  output logic [ADDR_SIZE:0]   det_count_o,
  output logic [ADDR_SIZE-1:0] det_addr_o
);

  localparam int unsigned FillW = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_LEN);
  localparam logic [ADDR_SIZE:0] DepthW = (ADDR_SIZE + 1)'(RAM_DEPTH);

  typedef enum logic {StIdle, StScan} state_e;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  state_e               state_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic                 busy_q, done_q, detect_q;
  logic [ADDR_SIZE:0]   det_count_q;
  logic [ADDR_SIZE-1:0] det_addr_q;
  logic [PAT_LEN-1:0]   shreg_q, shreg_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic [ADDR_SIZE:0]   remain_q;
  logic [ADDR_SIZE:0]   scan_len_eff;
  logic                 match;
  logic                 mem_we;

  assign data_out_o  = mem[rd_addr_q];
  assign dout_o      = data_out_o[BIT_SEL];
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign detect_o    = detect_q;
  assign det_count_o = det_count_q;
  assign det_addr_o  = det_addr_q;

  always_comb begin
    shreg_d      = shreg_q << 1;
    shreg_d[0]   = dout_o;
    fill_d       = (fill_q == FillMax) ? FillMax : fill_q + 1'b1;
    // A match needs a full window, so an all-zero reset register can't fake one.
    match        = (shreg_d == PATTERN) && (fill_d == FillMax);
    scan_len_eff = (scan_len_i > DepthW) ? DepthW : scan_len_i;
    mem_we       = (state_q == StIdle) && en_write_i;
  end

  // RAM contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[addr_i] <= data_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      detect_q    <= 1'b0;
      det_count_q <= '0;
      det_addr_q  <= '0;
      shreg_q     <= '0;
      fill_q      <= '0;
      remain_q    <= '0;
    end else begin
      done_q   <= 1'b0;
      detect_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!en_write_i) begin
            if (start_i) begin
              det_count_q <= '0;
              shreg_q     <= '0;
              fill_q      <= '0;
              remain_q    <= scan_len_eff;
              if (scan_len_eff == '0) begin
                done_q <= 1'b1;
              end else begin
                busy_q    <= 1'b1;
                rd_addr_q <= scan_base_i;
                state_q   <= StScan;
              end
            end else if (en_read_i) begin
              rd_addr_q <= addr_i;
            end
          end
        end
        StScan: begin
          shreg_q <= shreg_d;
          fill_q  <= fill_d;
          if (match) begin
            detect_q   <= 1'b1;
            det_addr_q <= rd_addr_q;
            if (det_count_q != '1) begin
              det_count_q <= det_count_q + 1'b1;
            end
          end
          remain_q <= remain_q - 1'b1;
          if (remain_q == (ADDR_SIZE + 1)'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_detector.sv
// Randomised self-checking bench for ram_scan_detector against a bit-list reference model.
module tb_ram_scan_detector;

  localparam int W = 8, A = 5, D = 32, BS = 3, PL = 3;
  localparam int PAT = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_write, en_read, start;
  logic [A-1:0] addr, scan_base, det_addr;
  logic [W-1:0] data_in, data_out;
  logic [A:0]   scan_len, det_count;
  logic         dout, busy, done, detect;

  int checks = 0, failures = 0;
  logic [W-1:0] mem_m [D];
  int det_addr_m = 0;

  always #5 clk = ~clk;

  ram_scan_detector dut (
    .clk_i(clk), .rst_ni(rst_n), .en_write_i(en_write), .en_read_i(en_read), .addr_i(addr),
    .data_in_i(data_in), .data_out_o(data_out), .dout_o(dout), .start_i(start),
    .scan_base_i(scan_base), .scan_len_i(scan_len), .busy_o(busy), .done_o(done),
    .detect_o(detect), .det_count_o(det_count), .det_addr_o(det_addr)
  );

  task automatic clear_inputs();
    en_write = 0; en_read = 0; start = 0; addr = '0; data_in = '0; scan_base = '0; scan_len = '0;
  endtask

  task automatic write_mem(input int a, input logic [W-1:0] d);
    @(negedge clk); en_write = 1; addr = a[A-1:0]; data_in = d;
    @(posedge clk); mem_m[a] = d;
    @(negedge clk); en_write = 0;
  endtask

  task automatic read_check(input int a, input string tag);
    @(negedge clk); en_read = 1; addr = a[A-1:0];
    @(posedge clk); #1;
    en_read = 0;
    checks++;
    if (data_out !== mem_m[a]) begin
      failures++; $display("FAIL %s data_out[%0d] got %h want %h", tag, a, data_out, mem_m[a]);
    end
    checks++;
    if (dout !== mem_m[a][BS]) begin
      failures++; $display("FAIL %s dout[%0d] got %b want %b", tag, a, dout, mem_m[a][BS]);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    checks++;
    if ({busy, done, detect} !== 3'b000 || det_count !== '0 || det_addr !== '0) begin
      failures++;
      $display("FAIL %s reset outputs got b=%b d=%b det=%b cnt=%0d addr=%0d want all 0",
               tag, busy, done, detect, det_count, det_addr);
    end
  endtask

  // Runs one scan and checks every cycle against a window-matching model over the bit list.
  task automatic do_scan(input int base, input int len, input bit noise, input string tag);
    int  l, cnt, w, k;
    bit  bits [D];
    bit  m;
    l = (len > D) ? D : len;
    for (int i = 0; i < l; i++) bits[i] = mem_m[(base + i) % D][BS];
    @(negedge clk); start = 1; scan_base = base[A-1:0]; scan_len = len[A:0];
    @(posedge clk); #1;
    checks++;
    if (busy !== (l > 0) || done !== (l == 0) || detect !== 1'b0 || det_count !== '0) begin
      failures++;
      $display("FAIL %s start-edge got b=%b d=%b det=%b cnt=%0d want b=%b d=%b det=0 cnt=0",
               tag, busy, done, detect, det_count, l > 0, l == 0);
    end
    if (l > 0) begin
      checks++;
      if (data_out !== mem_m[base % D]) begin
        failures++; $display("FAIL %s first word got %h want %h", tag, data_out, mem_m[base % D]);
      end
    end
    cnt = 0;
    for (int c = 1; c <= l; c++) begin
      @(negedge clk);
      start = 0;
      if (noise) begin
        en_write = 1; addr = (c == 1) ? 5'd2 : A'($urandom); data_in = W'($urandom);
        start = 1; en_read = 1'($urandom); scan_base = A'($urandom); scan_len = '1;
      end
      @(posedge clk); #1;
      k = c - 1;
      m = 0;
      if (k >= PL - 1) begin
        w = 0;
        for (int j = 0; j < PL; j++) w = (w << 1) | int'(bits[k - PL + 1 + j]);
        m = (w == PAT);
      end
      if (m) begin
        if (cnt < (1 << (A + 1)) - 1) cnt++;
        det_addr_m = (base + k) % D;
      end
      checks++;
      if (detect !== m || busy !== (c < l) || done !== (c == l)) begin
        failures++;
        $display("FAIL %s c=%0d got det=%b b=%b d=%b want det=%b b=%b d=%b",
                 tag, c, detect, busy, done, m, c < l, c == l);
      end
      checks++;
      if (det_count !== (A + 1)'(cnt) || det_addr !== A'(det_addr_m)) begin
        failures++;
        $display("FAIL %s c=%0d got cnt=%0d addr=%0d want cnt=%0d addr=%0d",
                 tag, c, det_count, det_addr, cnt, det_addr_m);
      end
      if (c < l) begin
        checks++;
        if (data_out !== mem_m[(base + c) % D]) begin
          failures++;
          $display("FAIL %s c=%0d word got %h want %h", tag, c, data_out, mem_m[(base + c) % D]);
        end
      end
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || det_count !== (A + 1)'(cnt) ||
        det_addr !== A'(det_addr_m)) begin
      failures++;
      $display("FAIL %s after got b=%b d=%b cnt=%0d addr=%0d want b=0 d=0 cnt=%0d addr=%0d",
               tag, busy, done, det_count, det_addr, cnt, det_addr_m);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs();
    #23;
    check_idle_zero("reset");
    @(negedge clk); rst_n = 1;
    write_mem(4, 8'hA5);
    read_check(4, "reset_read");
  endtask

  task automatic test_basic_scan();
    bit b [8];
    b = '{0, 0, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 8; i++) write_mem(i, {4'h5, b[i], 3'b010});
    do_scan(0, 8, 0, "basic");
  endtask

  task automatic test_wrap();
    write_mem(30, 8'h08); write_mem(31, 8'h00); write_mem(0, 8'h00); write_mem(1, 8'h08);
    do_scan(30, 4, 0, "wrap");
  endtask

  task automatic test_fill_zero();
    write_mem(0, 8'h08);
    do_scan(0, 1, 0, "fill_guard");
    do_scan(5, 0, 0, "zero_len");
  endtask

  task automatic test_ignored_clamp();
    write_mem(2, 8'h3C);
    do_scan(0, 32, 1, "ignored");
    read_check(2, "ignored_mem2");
    do_scan(7, 40, 0, "clamp");
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < 8; i++) write_mem(i, (i == 2 || i == 5) ? 8'h08 : 8'h00);
    @(negedge clk); start = 1; scan_base = '0; scan_len = 6'd8;
    @(posedge clk);
    @(negedge clk); start = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    det_addr_m = 0;
    #1;
    check_idle_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL mid_reset hold got d=%b b=%b want 0 0", done, busy);
      end
    end
    @(negedge clk); rst_n = 1;
    read_check(2, "mid_reset_mem");
    read_check(5, "mid_reset_mem");
    read_check(4, "mid_reset_mem");
  endtask

  task automatic test_random_scans();
    for (int i = 0; i < D; i++) write_mem(i, W'($urandom));
    for (int n = 0; n < 8; n++) begin
      do_scan(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 63)), n == 3, "random");
    end
    for (int n = 0; n < 4; n++) read_check(int'($urandom_range(0, D - 1)), "random_read");
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_wrap();
    test_fill_zero();
    test_ignored_clamp();
    test_reset_mid_scan();
    test_random_scans();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
